// File: rtl/histo_readout_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// histo_readout_if : byte stream (valid/ready) from the histogram readout
// Rev 1.0
// ---------------------------------------------------------------------------
interface histo_readout_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/histo_readout.sv
`default_nettype none
// ---------------------------------------------------------------------------
// histo_readout : walks channels 0..limit-1 and streams 33 bytes per channel
// Optional macro HISTO_CLEAR_ON_READ_EN adds a one-cycle resethist per channel.
// Rev 1.0
// ---------------------------------------------------------------------------
module histo_readout #(
  parameter int NCH    = 64,
  parameter int SETTLE = 3
) (
  input  wire logic         clk,
  input  wire logic         nrst,
  input  wire logic         start,
  input  wire logic         abort,
  input  wire logic [7:0]   nchan,
  input  wire logic [255:0] histos_in,
  output logic [7:0]        histostosend,
  output logic              resethist,
  histo_readout_if.master   tx,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0] c_NCH         = 8'(NCH);
  localparam logic [7:0] c_SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [5:0] c_LAST_BYTE   = 6'd32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SETTLE,
    S_CAPTURE,
    S_SEND,
`ifdef HISTO_CLEAR_ON_READ_EN
    S_CLEAR,
`endif
    S_NEXT,
    S_FINISH
  } state_t;

  state_t         r_state,  w_state_nx;
  logic [7:0]     r_limit,  w_limit_nx;
  logic [7:0]     r_chan,   w_chan_nx;
  logic [5:0]     r_byte,   w_byte_nx;
  logic [7:0]     r_settle, w_settle_nx;
  logic [255:0]   r_shadow, w_shadow_nx;
  logic [7:0]     r_tx_data, w_tx_data_nx;
  logic           r_tx_valid, w_tx_valid_nx;
  logic [7:0]     r_hts,    w_hts_nx;
  logic           r_busy,   w_busy_nx;
  logic           r_done,   w_done_nx;
  logic           r_resethist, w_resethist_nx;
  logic [8:0]     w_chan_inc;

  assign w_chan_inc = {1'b0, r_chan} + 9'd1;

  always_comb begin
    w_state_nx     = r_state;
    w_limit_nx     = r_limit;
    w_chan_nx      = r_chan;
    w_byte_nx      = r_byte;
    w_settle_nx    = r_settle;
    w_shadow_nx    = r_shadow;
    w_tx_data_nx   = r_tx_data;
    w_tx_valid_nx  = r_tx_valid;
    w_hts_nx       = r_hts;
    w_busy_nx      = r_busy;
    w_done_nx      = 1'b0;
    w_resethist_nx = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_limit_nx = (nchan > c_NCH) ? c_NCH : nchan;
          w_chan_nx  = 8'd0;
          w_busy_nx  = 1'b1;
          w_state_nx = (nchan == 8'd0) ? S_FINISH : S_SELECT;
        end
      end
      S_SELECT: begin
        w_hts_nx    = r_chan;
        w_settle_nx = 8'd0;
        w_state_nx  = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_settle == c_SETTLE_LAST) begin
          w_state_nx = S_CAPTURE;
        end else begin
          w_settle_nx = r_settle + 8'd1;
        end
      end
      S_CAPTURE: begin
        // Channel index goes out first, straight from the counter.
        w_shadow_nx   = histos_in;
        w_byte_nx     = 6'd0;
        w_tx_data_nx  = r_chan;
        w_tx_valid_nx = 1'b1;
        w_state_nx    = S_SEND;
      end
      S_SEND: begin
        if (tx.tx_ready) begin
          if (r_byte == c_LAST_BYTE) begin
            w_tx_valid_nx = 1'b0;
`ifdef HISTO_CLEAR_ON_READ_EN
            w_resethist_nx = 1'b1;
            w_state_nx     = S_CLEAR;
`else
            w_state_nx     = S_NEXT;
`endif
          end else begin
            // Byte k+1 is shadow byte k: words are already little-endian in the flat vector.
            w_byte_nx    = r_byte + 6'd1;
            w_tx_data_nx = r_shadow[{r_byte[4:0], 3'b000} +: 8];
          end
        end
      end
`ifdef HISTO_CLEAR_ON_READ_EN
      S_CLEAR: begin
        w_state_nx = S_NEXT;
      end
`endif
      S_NEXT: begin
        w_chan_nx  = w_chan_inc[7:0];
        w_state_nx = (w_chan_inc < {1'b0, r_limit}) ? S_SELECT : S_FINISH;
      end
      S_FINISH: begin
        w_done_nx  = 1'b1;
        w_busy_nx  = 1'b0;
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    if (abort && (r_state != S_IDLE) && (r_state != S_FINISH)) begin
      w_tx_valid_nx  = 1'b0;
      w_resethist_nx = 1'b0;
      w_state_nx     = S_FINISH;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= S_IDLE;
      r_limit     <= 8'd0;
      r_chan      <= 8'd0;
      r_byte      <= 6'd0;
      r_settle    <= 8'd0;
      r_shadow    <= '0;
      r_tx_data   <= 8'd0;
      r_tx_valid  <= 1'b0;
      r_hts       <= 8'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_resethist <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_limit     <= w_limit_nx;
      r_chan      <= w_chan_nx;
      r_byte      <= w_byte_nx;
      r_settle    <= w_settle_nx;
      r_shadow    <= w_shadow_nx;
      r_tx_data   <= w_tx_data_nx;
      r_tx_valid  <= w_tx_valid_nx;
      r_hts       <= w_hts_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
      r_resethist <= w_resethist_nx;
    end
  end

  assign histostosend = r_hts;
  assign tx.tx_data   = r_tx_data;
  assign tx.tx_valid  = r_tx_valid;
  assign busy         = r_busy;
  assign done         = r_done;
`ifdef HISTO_CLEAR_ON_READ_EN
  assign resethist    = r_resethist;
`else
  assign resethist    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_histo_readout.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_histo_readout : random/directed readouts checked against a byte-list model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_histo_readout;
  localparam int NCH    = 64;
  localparam int SETTLE = 3;
  localparam int BUDGET = 6000;

  logic         clk   = 1'b0;
  logic         nrst  = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [7:0]   nchan = 8'd0;
  logic [255:0] histos_in;
  logic [7:0]   histostosend;
  logic         resethist;
  logic         busy;
  logic         done;

  histo_readout_if tx_if ();

  histo_readout #(.NCH(NCH), .SETTLE(SETTLE)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .start        (start),
    .abort        (abort),
    .nchan        (nchan),
    .histos_in    (histos_in),
    .histostosend (histostosend),
    .resethist    (resethist),
    .tx           (tx_if),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Histogram source: per-channel data, two-register select latency, garbage while streaming
  logic [255:0] chan_data [0:255];
  logic [7:0]   src1 = 8'd0, src2 = 8'd0;
  logic [255:0] garbage = '0;
  always @(posedge clk) begin
    src1 <= histostosend;
    src2 <= src1;
    for (int k = 0; k < 8; k++) garbage[32*k +: 32] <= $urandom;
  end
  assign histos_in = tx_if.tx_valid ? garbage : chan_data[src2];

  // Sink ready pattern: 0 always, 1 one-in-three, 2 random, 3 held low
  int rdy_mode = 0;
  int rdy_phase = 0;
  initial tx_if.tx_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    rdy_phase = (rdy_phase + 1) % 3;
    case (rdy_mode)
      0:       tx_if.tx_ready = 1'b1;
      1:       tx_if.tx_ready = (rdy_phase == 0);
      2:       tx_if.tx_ready = 1'($urandom_range(0, 1));
      default: tx_if.tx_ready = 1'b0;
    endcase
  end

  // Monitor
  logic [7:0] rx_q [$];
  logic [7:0] clr_q [$];
  logic [7:0] exp_q [$];
  int   done_cnt   = 0;
  int   valid_seen = 0;
  logic prev_stall = 1'b0;
  logic prev_abort = 1'b0;
  logic prev_rh    = 1'b0;
  logic [7:0] prev_data = 8'd0;

  always @(negedge clk) begin
    if (nrst) begin
      if (prev_stall && !prev_abort) begin
        check("hold_valid", 64'(tx_if.tx_valid), 64'd1);
        check("hold_data", 64'(tx_if.tx_data), 64'(prev_data));
      end
      if (tx_if.tx_valid && tx_if.tx_ready) rx_q.push_back(tx_if.tx_data);
      if (tx_if.tx_valid) valid_seen <= valid_seen + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (resethist) begin
        clr_q.push_back(histostosend);
        check("rh_width", 64'(prev_rh), 64'd0);
      end
    end
    prev_stall <= nrst && tx_if.tx_valid && !tx_if.tx_ready;
    prev_data  <= tx_if.tx_data;
    prev_abort <= abort;
    prev_rh    <= resethist;
  end

  function automatic logic [7:0] rxb(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 8'hxx;
  endfunction

  // Reference: for each channel, its index then its 32 data bytes in address order
  task automatic build_exp(input int n);
    int lim;
    lim = (n > NCH) ? NCH : n;
    exp_q.delete();
    for (int ch = 0; ch < lim; ch++) begin
      exp_q.push_back(8'(ch));
      for (int b = 0; b < 32; b++) exp_q.push_back(chan_data[ch][8*b +: 8]);
    end
  endtask

  task automatic pulse_start(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    nchan = 8'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_clears(input string tag, input int n);
    int lim;
    lim = (n > NCH) ? NCH : n;
`ifdef HISTO_CLEAR_ON_READ_EN
    check({tag, "_rh_cnt"}, 64'(clr_q.size()), 64'(lim));
    for (int i = 0; i < lim && i < clr_q.size(); i++)
      check({tag, "_rh_ch"}, 64'(clr_q[i]), 64'(i));
`else
    check({tag, "_rh_cnt"}, 64'(clr_q.size()), 64'(lim - lim));
`endif
  endtask

  task automatic run_readout(input int n, input int mode, input bit poke, input string tag);
    int d0, cyc;
    build_exp(n);
    rx_q.delete();
    clr_q.delete();
    rdy_mode = mode;
    d0 = done_cnt;
    pulse_start(n);
    cyc = 0;
    while (done_cnt == d0 && cyc < BUDGET) begin
      @(negedge clk); #1;
      cyc++;
      if (poke && cyc == 40) begin start = 1'b1; nchan = 8'($urandom_range(1, 255)); end
      if (poke && cyc == 41) start = 1'b0;
    end
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_len"}, 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) check({tag, "_byte"}, 64'(rxb(i)), 64'(exp_q[i]));
    check_clears(tag, n);
  endtask

  initial begin
    int d0, cyc, v0;
    for (int c = 0; c < 256; c++)
      for (int k = 0; k < 8; k++) chan_data[c][32*k +: 32] = $urandom;

    // Reset state
    #1 nrst = 1'b0;
    #2;
    check("rst_valid", 64'(tx_if.tx_valid), 64'd0);
    check("rst_data", 64'(tx_if.tx_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hts", 64'(histostosend), 64'd0);
    check("rst_rh", 64'(resethist), 64'd0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;

    // Two channels, known word0
    chan_data[0][31:0] = 32'h11223344;
    chan_data[1][31:0] = 32'h11223344;
    run_readout(2, 0, 1'b0, "two_ch");
    check("two_b0", 64'(rxb(0)), 64'h00);
    check("two_b1", 64'(rxb(1)), 64'h44);
    check("two_b2", 64'(rxb(2)), 64'h33);
    check("two_b3", 64'(rxb(3)), 64'h22);
    check("two_b4", 64'(rxb(4)), 64'h11);
    check("two_b33", 64'(rxb(33)), 64'h01);

    // Sink ready one cycle in three
    run_readout(1, 1, 1'b0, "stall");

    // nchan = 0
    d0 = done_cnt;
    v0 = valid_seen;
    rdy_mode = 0;
    pulse_start(0);
    cyc = 0;
    while (done_cnt == d0 && cyc < 20) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("n0_latency", 64'(cyc), 64'd2);
    repeat (3) @(negedge clk);
    #1;
    check("n0_done", 64'(done_cnt - d0), 64'd1);
    check("n0_valid", 64'(valid_seen - v0), 64'd0);

    // Oversized request clamps to NCH
    run_readout(200, 0, 1'b0, "clamp");

    // Start and abort together in IDLE
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; nchan = 8'd3;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk); #1;
    check("sa_busy", 64'(busy), 64'd0);

    // Random readouts, some with a start while busy
    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < 8; c++)
        for (int k = 0; k < 8; k++) chan_data[c][32*k +: 32] = $urandom;
      run_readout(int'($urandom_range(1, 5)), (it % 3 == 0) ? 0 : 2, bit'(it % 2), "rand");
    end

    // Abort after ten bytes of channel 0
    build_exp(2);
    rx_q.delete();
    clr_q.delete();
    rdy_mode = 0;
    d0 = done_cnt;
    pulse_start(2);
    cyc = 0;
    while (rx_q.size() < 10 && cyc < 200) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("ab_reach", 64'(rx_q.size()), 64'd10);
    rdy_mode = 3;
    @(posedge clk); #2;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("ab_valid", 64'(tx_if.tx_valid), 64'd0);
    @(negedge clk);
    @(negedge clk); #1;
    check("ab_done", 64'(done_cnt - d0), 64'd1);
    check("ab_busy", 64'(busy), 64'd0);
    rdy_mode = 0;
    repeat (30) @(negedge clk);
    #1;
    check("ab_len", 64'(rx_q.size()), 64'd10);
    for (int i = 0; i < 10; i++) check("ab_byte", 64'(rxb(i)), 64'(exp_q[i]));
    check("ab_rh", 64'(clr_q.size()), 64'd0);

    // Reset while streaming
    rx_q.delete();
    rdy_mode = 0;
    d0 = done_cnt;
    pulse_start(3);
    cyc = 0;
    while (rx_q.size() < 40 && cyc < 300) begin
      @(negedge clk); #1;
      cyc++;
    end
    #2 nrst = 1'b0;
    #1;
    check("mr_valid", 64'(tx_if.tx_valid), 64'd0);
    check("mr_data", 64'(tx_if.tx_data), 64'd0);
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_done", 64'(done), 64'd0);
    check("mr_hts", 64'(histostosend), 64'd0);
    check("mr_rh", 64'(resethist), 64'd0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("mr_nodone", 64'(done_cnt - d0), 64'd0);
    run_readout(1, 2, 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/histo_readout.md
HISTO_READOUT -- requirements
Module: histo_readout

Interface
REQ-001 Parameters SHALL be:
- NCH, default 64, number of input channels available for readout.
- SETTLE, default 3, clk cycles to wait after changing histostosend before capture.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock (same domain as the trigger logic's histogram outputs)
- nrst  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse that begins a readout
- abort  in  1  single-cycle pulse that terminates the readout
- nchan  in  8  number of channels to read, starting from channel 0
- histos_in  in  256  histogram words 0..7, 32 bits each; word k at bits [32k+31:32k]
- histostosend  out  8  channel index presented to the histogram source
- resethist  out  1  clear request for the selected channel's histograms
- tx_data  out  8  stream byte
- tx_valid  out  1  stream byte valid
- tx_ready  in  1  sink accepts the byte
- busy  out  1  readout in progress
- done  out  1  single-cycle pulse when a readout ends
REQ-003 Clock and reset SHALL be one clock (clk) and an asynchronous, active-low reset (nrst).

Function
REQ-004 State machine states SHALL be IDLE, SELECT, SETTLE, CAPTURE, SEND, CLEAR, NEXT and FINISH.
REQ-005 IDLE: on start, latch min(nchan,NCH) as limit, set the channel counter to 0 and assert busy; a limit of 0 SHALL go directly to FINISH.
REQ-006 SELECT: drive histostosend with the channel counter; the register SHALL hold this value until NEXT.
REQ-007 SETTLE: wait exactly SETTLE cycles; this covers the source's two-register select-to-output latency plus margin.
REQ-008 CAPTURE: copy histos_in into a 256-bit shadow register in one cycle.
REQ-009 SEND: emit 33 bytes per channel:
- byte 0 = channel index
- then words 0..7, each little-endian (byte 1 = word0[7:0] … byte 32 = word7[31:24])
REQ-010 Handshake:
- A byte transfers on a cycle with tx_valid and tx_ready both high.
- tx_data SHALL stay stable and tx_valid SHALL stay high until that transfer.
- tx_valid SHALL never drop without a transfer, except on abort or reset.
REQ-011 After the 33rd transfer, go to CLEAR (macro enabled) or NEXT (macro disabled).
REQ-012 NEXT: increment the channel counter; go to SELECT if counter < limit, else FINISH.
REQ-013 FINISH: pulse done for one cycle, deassert busy, return to IDLE.
REQ-014 start received while busy SHALL be ignored.
REQ-015 abort in any non-IDLE state SHALL clear tx_valid and resethist in the same edge and go to FINISH; the partial channel SHALL NOT be completed.
REQ-016 Simultaneous start and abort in IDLE SHALL be ignored.
REQ-017 The byte counter (6 bits) and channel counter (8 bits) SHALL never wrap; termination comparisons are exact.
REQ-018 Input changes on histos_in outside CAPTURE SHALL NOT affect transmitted bytes.

Reset
REQ-019 nrst low SHALL asynchronously force IDLE and set the following to 0: busy, done, tx_valid, tx_data, resethist, histostosend, both counters and the shadow register.
REQ-020 Reset mid-readout SHALL discard the readout with no done pulse.

Configuration
REQ-021 Macro HISTO_CLEAR_ON_READ_EN:
- Defined: CLEAR asserts resethist for exactly 1 cycle with histostosend still holding the channel just sent, then goes to NEXT.
- Undefined: the CLEAR state is not built and resethist is tied to 0.

Verification
REQ-022 nchan=2, tx_ready=1, histos_in word0=0x11223344 for both channels -> 66 bytes sent; bytes 0..4 = 00,44,33,22,11; byte 33 = 01; then done pulse.
REQ-023 nchan=1, tx_ready toggling 1-of-3 cycles -> 33 bytes in order, no duplicates or drops, tx_data stable while stalled.
REQ-024 nchan=0 -> done within 2 cycles of start, tx_valid never high; nchan=200 -> exactly 64×33 bytes.
REQ-025 abort after byte 10 of channel 0 -> tx_valid low next edge, done pulse, busy low, no further bytes.
REQ-026 With HISTO_CLEAR_ON_READ_EN, nchan=3 -> three 1-cycle resethist pulses with histostosend=0,1,2; without the macro -> resethist always 0.
REQ-027 nrst low during SEND -> all outputs 0 immediately, no done pulse; a later start reads from channel 0 normally.
